// File: rtl/dm_cache_controller_pkg.sv
// Shared definitions for the direct-mapped read-only cache: widths, FSM states,
// address field helpers.
package dm_cache_controller_pkg;

    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned BLOCK_WORDS = 4;

    typedef logic [BLOCK_WORDS-1:0][31:0] line_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WAIT,
        RELEASE,
        DRAIN
    } state_e;

    function automatic int unsigned line_index(input int unsigned adr, input int unsigned idx_w);
        return (adr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic int unsigned line_tag(input int unsigned adr, input int unsigned idx_w);
        return adr >> (idx_w + 2);
    endfunction

    function automatic int unsigned block_addr(input int unsigned adr);
        return adr & ~32'd3;
    endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// CPU load-path and block-read memory signals of the cache controller.
interface dm_cache_controller_if #(
    parameter int unsigned ADDR_W = dm_cache_controller_pkg::ADDR_W,
    parameter int unsigned CNT_W  = 16
);
    logic              cpu_rd;
    logic [ADDR_W-1:0] cpu_adr;
    logic [31:0]       cpu_data;
    logic              cpu_ready;
    logic              mem_start;
    logic              mem_forc;
    logic [ADDR_W-1:0] mem_adr;
    logic              mem_ready;
    logic [31:0]       mem_r1;
    logic [31:0]       mem_r2;
    logic [31:0]       mem_r3;
    logic [31:0]       mem_r4;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  cpu_rd, cpu_adr, mem_ready, mem_r1, mem_r2, mem_r3, mem_r4,
        output cpu_data, cpu_ready, mem_start, mem_forc, mem_adr, hit_count, miss_count
    );

    modport master (
        output cpu_rd, cpu_adr, mem_ready, mem_r1, mem_r2, mem_r3, mem_r4,
        input  cpu_data, cpu_ready, mem_start, mem_forc, mem_adr, hit_count, miss_count
    );

endinterface

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read port,
// whole-line write port; only the valid bits are reset.
module dm_cache_array
    import dm_cache_controller_pkg::*;
#(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output line_t            rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  line_t            wr_line
);

    localparam int unsigned LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    line_t            data_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data keep their contents across reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped read-only data cache: 1-cycle hits, block refill via the
// memory's start/ready/forc handshake, hit/miss counters.
module dm_cache_controller #(
    parameter int unsigned ADDR_W      = dm_cache_controller_pkg::ADDR_W,
    parameter int unsigned CACHE_WORDS = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dm_cache_controller_if.slave  bus
);
    import dm_cache_controller_pkg::*;

    localparam int unsigned IDX_W = $clog2(CACHE_WORDS) - 2;
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    state_e            state_q, state_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [31:0]       cpu_data_q, cpu_data_d;
    logic              mem_start_q, mem_start_d;
    logic              mem_forc_q, mem_forc_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    line_t             fill_q, fill_d;
    logic [1:0]        req_off_q, req_off_d;

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    line_t             rd_line;
    logic              hit;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    line_t             mem_line;

    assign rd_idx   = IDX_W'(line_index(32'(bus.cpu_adr), IDX_W));
    assign req_tag  = TAG_W'(line_tag(32'(bus.cpu_adr), IDX_W));
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign wr_idx   = IDX_W'(line_index(32'(mem_adr_q), IDX_W));
    assign wr_tag   = TAG_W'(line_tag(32'(mem_adr_q), IDX_W));
    assign mem_line = {bus.mem_r4, bus.mem_r3, bus.mem_r2, bus.mem_r1};

    dm_cache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_line  (mem_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // cpu_ready_q masks the lookup in the response cycle, where cpu_rd is still high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = IDLE;
            IDLE:    if (bus.cpu_rd && !cpu_ready_q && !hit) state_d = WAIT;
            WAIT:    if (bus.mem_ready) state_d = RELEASE;
            RELEASE: state_d = DRAIN;
            DRAIN:   if (!bus.mem_ready) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        cpu_ready_d = 1'b0;
        cpu_data_d  = cpu_data_q;
        mem_start_d = mem_start_q;
        mem_forc_d  = 1'b0;
        mem_adr_d   = mem_adr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_d      = fill_q;
        req_off_d   = req_off_q;
        wr_en       = 1'b0;
        case (state_q)
            INIT: begin
                mem_forc_d  = 1'b1;
                mem_start_d = 1'b0;
            end
            IDLE: begin
                if (bus.cpu_rd && !cpu_ready_q) begin
                    if (hit) begin
                        cpu_ready_d = 1'b1;
                        cpu_data_d  = rd_line[bus.cpu_adr[1:0]];
                        hit_cnt_d   = hit_cnt_q + 1'b1;
                    end else begin
                        miss_cnt_d  = miss_cnt_q + 1'b1;
                        mem_adr_d   = ADDR_W'(block_addr(32'(bus.cpu_adr)));
                        mem_start_d = 1'b1;
                        req_off_d   = bus.cpu_adr[1:0];
                    end
                end
            end
            // Start drops and forc rises on the same edge, so RELEASE shows start=0, forc=1.
            WAIT: begin
                if (bus.mem_ready) begin
                    wr_en       = 1'b1;
                    fill_d      = mem_line;
                    mem_start_d = 1'b0;
                    mem_forc_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.mem_ready) begin
                    cpu_ready_d = 1'b1;
                    cpu_data_d  = fill_q[req_off_q];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ready_q <= 1'b0;
            cpu_data_q  <= '0;
            mem_start_q <= 1'b0;
            mem_forc_q  <= 1'b0;
            mem_adr_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            fill_q      <= '0;
            req_off_q   <= '0;
        end else begin
            cpu_ready_q <= cpu_ready_d;
            cpu_data_q  <= cpu_data_d;
            mem_start_q <= mem_start_d;
            mem_forc_q  <= mem_forc_d;
            mem_adr_q   <= mem_adr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            fill_q      <= fill_d;
            req_off_q   <= req_off_d;
        end
    end

    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.cpu_data   = cpu_data_q;
    assign bus.mem_start  = mem_start_q;
    assign bus.mem_forc   = mem_forc_q;
    assign bus.mem_adr    = mem_adr_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_controller.sv
// Randomized self-checking bench for dm_cache_controller against a line-level
// cache model and a behavioural block-read memory.
module tb_dm_cache_controller;

    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned CACHE_WORDS = 1024;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned LINES       = CACHE_WORDS / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dm_cache_controller_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

    dm_cache_controller #(
        .ADDR_W      (ADDR_W),
        .CACHE_WORDS (CACHE_WORDS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: word value is the address, optionally scrambled by salt in the upper half.
    int unsigned mem_delay = 0;
    logic [15:0] salt = '0;
    int unsigned mem_cnt = 0;
    logic        mem_ready_m = 1'b1;
    logic [31:0] r_m [4];

    function automatic logic [31:0] mem_word(input int unsigned a);
        return a ^ {salt, 16'h0000};
    endfunction

    assign bus.mem_ready = mem_ready_m;
    assign bus.mem_r1    = r_m[0];
    assign bus.mem_r2    = r_m[1];
    assign bus.mem_r3    = r_m[2];
    assign bus.mem_r4    = r_m[3];

    always @(posedge clk) begin
        if (bus.mem_forc) begin
            mem_ready_m <= 1'b0;
            mem_cnt     <= 0;
        end else if (bus.mem_start && !mem_ready_m) begin
            if (mem_cnt >= mem_delay) begin
                mem_ready_m <= 1'b1;
                for (int i = 0; i < 4; i++) r_m[i] <= mem_word(32'(bus.mem_adr) + 32'(i));
                mem_cnt <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Protocol monitor.
    int unsigned overlap = 0, start_ready = 0, adr_moved = 0;
    int unsigned ready_pulses = 0, ready_long = 0, forc_cycles = 0;
    logic start_prev = 1'b0, ready_prev = 1'b0;
    logic [ADDR_W-1:0] adr_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            start_prev = 1'b0;
            ready_prev = 1'b0;
        end else begin
            if (bus.mem_start && bus.mem_forc) overlap++;
            if (bus.mem_start && !start_prev && bus.mem_ready) start_ready++;
            if (bus.mem_start && start_prev && bus.mem_adr != adr_prev) adr_moved++;
            if (bus.cpu_ready) ready_pulses++;
            if (bus.cpu_ready && ready_prev) ready_long++;
            if (bus.mem_forc) forc_cycles++;
            start_prev = bus.mem_start;
            ready_prev = bus.cpu_ready;
            adr_prev   = bus.mem_adr;
        end
    end

    // Reference cache model.
    logic        mv [LINES];
    int unsigned mt [LINES];
    logic [31:0] md [LINES][4];
    int unsigned m_hits = 0, m_misses = 0, req_count = 0;

    task automatic model_reset();
        for (int i = 0; i < int'(LINES); i++) mv[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"},   bus.hit_count,  m_hits   % (1 << CNT_W));
        check({tag, "_misses"}, bus.miss_count, m_misses % (1 << CNT_W));
    endtask

    task automatic wait_init();
        int unsigned f0;
        f0 = forc_cycles;
        repeat (4) @(negedge clk);
        check("init_forc_cycles", forc_cycles - f0, 1);
        check("init_clears_ready", bus.mem_ready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_ready"}, bus.cpu_ready, 0);
        check({tag, "_cpu_data"},  bus.cpu_data, 0);
        check({tag, "_mem_start"}, bus.mem_start, 0);
        check({tag, "_mem_forc"},  bus.mem_forc, 0);
        check({tag, "_mem_adr"},   bus.mem_adr, 0);
        check({tag, "_hit_cnt"},   bus.hit_count, 0);
        check({tag, "_miss_cnt"},  bus.miss_count, 0);
    endtask

    // b2b: request was raised during the previous response cycle, which the cache ignores.
    task automatic do_read(input int unsigned a, input bit b2b, input bit full);
        int unsigned idx, tg, off, blk, cyc, f0;
        bit exp_hit, saw_start, got;
        logic [ADDR_W-1:0] start_adr;
        logic [31:0] exp_d;
        idx = (a >> 2) % LINES;
        tg  = a >> 10;
        off = a & 3;
        blk = a & ~32'd3;
        exp_hit = mv[idx] && (mt[idx] == tg);
        exp_d   = exp_hit ? md[idx][off] : mem_word(a);
        f0 = forc_cycles;
        req_count++;
        bus.cpu_rd  = 1'b1;
        bus.cpu_adr = ADDR_W'(a);
        saw_start = 0; got = 0; cyc = 0; start_adr = '0;
        while (cyc < 300 && !got) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_start && !saw_start) begin
                saw_start = 1;
                start_adr = bus.mem_adr;
            end
            if (bus.cpu_ready) got = 1;
        end
        check("response_timeout", got, 1);
        if (exp_hit) m_hits++;
        else begin
            m_misses++;
            mv[idx] = 1'b1;
            mt[idx] = tg;
            for (int i = 0; i < 4; i++) md[idx][i] = mem_word(blk + 32'(i));
        end
        check("data", bus.cpu_data, exp_d);
        if (full) begin
            check("miss_path", saw_start, !exp_hit);
            check("latency", cyc, (exp_hit ? 1 : 5 + mem_delay) + (b2b ? 1 : 0));
            check("forc_per_request", forc_cycles - f0, exp_hit ? 0 : 1);
            if (!exp_hit) check("mem_adr", start_adr, blk);
        end
        check_counters("cnt");
    endtask

    task automatic idle();
        bus.cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_rd  = 1'b0;
        bus.cpu_adr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        wait_init();

        // Directed: cold miss, spatial hit, conflicts, top block.
        do_read(32'h0005, 0, 1); idle();
        do_read(32'h0006, 0, 1); idle();
        do_read(32'h0405, 0, 1); idle();
        do_read(32'h0005, 0, 1); idle();
        check("conflict_misses", bus.miss_count, 3);
        do_read(32'h7FFF, 0, 1); idle();
        do_read(32'h7FFC, 0, 1);
        do_read(32'h7FFD, 1, 1); idle();

        // Slow memory.
        mem_delay = 10;
        do_read(32'h0123, 0, 1); idle();
        mem_delay = 0;

        // Reset mid-miss while waiting on slow memory.
        mem_delay = 10;
        bus.cpu_rd  = 1'b1;
        bus.cpu_adr = ADDR_W'(32'h0010);
        repeat (4) @(negedge clk);
        check("wait_start_high", bus.mem_start, 1);
        rst = 1'b1;
        #1 check_reset_outputs("mid_miss");
        bus.cpu_rd = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        mem_delay = 0;
        do_read(32'h0005, 0, 1); idle();
        do_read(32'h0010, 0, 1); idle();

        // Counter wrap on repeated hits.
        for (int i = 0; i < 300; i++) begin
            do_read(32'h0006, (i % 3) != 0 && i != 0, 0);
            if ((i % 3) == 2) idle();
        end
        idle();

        // Randomized traffic over a small set of tags to mix hits, conflicts and refills.
        for (int i = 0; i < 250; i++) begin
            int unsigned a;
            bit b;
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 32'h7FFF);
            else a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) salt = 16'($urandom);
            mem_delay = $urandom_range(0, 3);
            b = (i != 0) && $urandom_range(0, 1) == 1;
            if (!b && i != 0) idle();
            do_read(a, b, 1);
        end
        idle();
        repeat (3) @(negedge clk);

        check("start_forc_overlap", overlap, 0);
        check("start_while_ready", start_ready, 0);
        check("mem_adr_moved", adr_moved, 0);
        check("ready_pulse_count", ready_pulses, req_count);
        check("ready_wider_than_one", ready_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
